// File: rtl/spi_w25q_read_arbiter_pkg.sv
// Shared types and default sizing for the W25Q read arbiter slice.
package spi_w25q_read_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 24;
    localparam int DATA_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/spi_w25q_read_arbiter_if.sv
// Requester-side and reader-side signal bundle of the W25Q read arbiter.
interface spi_w25q_read_arbiter_if
    import spi_w25q_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rd_start;
    logic [ADDR_W-1:0]         rd_addr;
    logic                      rd_busy;
    logic [DATA_W-1:0]         rd_data;

    modport slave (
        input  req_valid, req_addr, rd_busy, rd_data,
        output req_ready, rsp_valid, rsp_data, rd_start, rd_addr
    );

    modport master (
        output req_valid, req_addr, rd_busy, rd_data,
        input  req_ready, rsp_valid, rsp_data, rd_start, rd_addr
    );
endinterface

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping.
module spi_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [IDX_W-1:0] cand;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        any   = |req;
        // Walk from farthest to nearest so the nearest requester after ptr wins last.
        for (int k = N; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end
endmodule

// File: rtl/spi_w25q_read_arbiter.sv
// Round-robin arbiter sharing one spi_w25q_read_32b reader among NUM_REQ requesters.
// Define SPI_W25Q_ARB_CACHE_EN to add a one-entry last-read result cache.
module spi_w25q_read_arbiter
    import spi_w25q_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input logic clk,
    input logic rst_n,
    spi_w25q_read_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [ADDR_W-1:0]  grant_addr;
    logic               accept;
    logic               hit;
    logic [DATA_W-1:0]  hit_data;

    spi_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A stale read left running across reset must finish before the next grant.
    assign accept        = (state == IDLE) && !bus.rd_busy && pick_any;
    assign bus.req_ready = accept ? pick_grant : '0;

    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) grant_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        end
    end

`ifdef SPI_W25Q_ARB_CACHE_EN
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;
    logic              cache_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               cache_vld <= 1'b0;
        else if (state == WAIT && !bus.rd_busy)   cache_vld <= 1'b1;
    end

    // NOTE: the cache payload has no reset; cache_vld alone decides whether it is usable.
    always_ff @(posedge clk) begin
        if (state == WAIT && !bus.rd_busy) begin
            last_addr <= bus.rd_addr;
            last_data <= bus.rd_data;
        end
    end

    assign hit      = cache_vld && (grant_addr == last_addr);
    assign hit_data = last_data;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // NOTE: all state and registered outputs use non-blocking assignments to avoid ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= IDX_W'(NUM_REQ - 1);
            owner         <= '0;
            bus.rd_start  <= 1'b0;
            bus.rd_addr   <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= '0;
            case (state)
                IDLE: if (accept) begin
                    rr_ptr      <= pick_idx;
                    owner       <= pick_idx;
                    bus.rd_addr <= grant_addr;
                    if (hit) begin
                        bus.rsp_data  <= hit_data;
                        bus.rsp_valid <= pick_grant;
                        state         <= DONE;
                    end else begin
                        bus.rd_start <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                // busy already high counts as the acknowledge, so start is never re-issued.
                LAUNCH: if (bus.rd_busy) begin
                    bus.rd_start <= 1'b0;
                    state        <= WAIT;
                end
                WAIT: if (!bus.rd_busy) begin
                    bus.rsp_data  <= bus.rd_data;
                    bus.rsp_valid <= NUM_REQ'(1) << owner;
                    state         <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_w25q_read_arbiter.sv
// Randomized bench for spi_w25q_read_arbiter against a transaction-level round-robin model.
module tb_spi_w25q_read_arbiter;
    import spi_w25q_read_arbiter_pkg::*;

    localparam int N     = 4;
    localparam int AW    = 24;
    localparam int DW    = 32;
    localparam int NEVER = 32'h7fff_ffff;
`ifdef SPI_W25Q_ARB_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic clk;
    logic rst_n;

    spi_w25q_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    spi_w25q_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int mode  = 0;   // 0: requesters only drop on grant, 1: all held, 2: random

    // Transaction-level model of the arbiter
    int ptr, owner, g_cyc, due;
    bit outst, hit;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data, pend_data;
    bit c_vld;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;

    // Flash reader stand-in (no reset, like the real one)
    int cnt;
    int lat_fixed = 0;
    logic [AW-1:0] r_addr;

    bit snap_start;
    logic [AW-1:0] snap_addr;
    int snap_grant;

    int t_g, t_r;
    logic [DW-1:0] t_d;
    int glog[$];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 24'h010000) return 32'hDEADBEEF;
        return {a[7:0] ^ 8'hA5, a} ^ 32'h1357_9BDF;
    endfunction

    function automatic int rr_model(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 24'h000100;
            1:       return 24'h010000;
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        ptr = N - 1; outst = 0; hit = 0; due = NEVER; g_cyc = -10;
        exp_data = '0; c_vld = 0;
    endtask

    // Compare process body, run once per cycle at the falling edge.
    task automatic compare();
        logic [N-1:0]  exp_rdy, exp_rsp;
        logic [DW-1:0] exp_rd;
        int grant;
        snap_start = bus.rd_start;
        snap_addr  = bus.rd_addr;
        snap_grant = -1;
        if (!rst_n) begin
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_rsp_valid", bus.rsp_valid, 0);
            check("rst_rsp_data",  bus.rsp_data, 0);
            check("rst_rd_start",  bus.rd_start, 0);
            check("rst_rd_addr",   bus.rd_addr, 0);
            return;
        end
        exp_rsp = (outst && cyc == due) ? N'(1) << owner : '0;
        exp_rd  = (outst && cyc == due) ? pend_data : exp_data;
        check("rsp_valid", bus.rsp_valid, exp_rsp);
        check("rsp_data",  bus.rsp_data, exp_rd);
        check("rd_start",  bus.rd_start, outst && !hit && (cyc == g_cyc + 1 || cyc == g_cyc + 2));
        if (outst && !hit && cyc > g_cyc && cyc < due) check("rd_addr", bus.rd_addr, exp_addr);
        grant   = (!outst && !bus.rd_busy) ? rr_model(bus.req_valid, ptr) : -1;
        exp_rdy = (grant >= 0) ? N'(1) << grant : '0;
        check("req_ready", bus.req_ready, exp_rdy);

        if (bus.req_ready != 0) begin
            glog.push_back($clog2(bus.req_ready));
            if (t_g < 0) t_g = cyc;
        end
        if (bus.rsp_valid != 0 && t_r < 0) begin
            t_r = cyc;
            t_d = bus.rsp_data;
        end

        if (outst && cyc == due) begin
            outst    = 0;
            exp_data = pend_data;
            if (CACHE && !hit) begin
                c_vld = 1; c_addr = exp_addr; c_data = pend_data;
            end
        end
        if (grant >= 0) begin
            snap_grant = grant;
            ptr = grant; owner = grant; outst = 1; g_cyc = cyc;
            exp_addr = bus.req_addr[grant*AW +: AW];
            hit = c_vld && (c_addr == exp_addr);
            if (hit) begin
                due = cyc + 1;
                pend_data = c_data;
            end else begin
                due = NEVER;
                pend_data = mem_word(exp_addr);
            end
        end
    endtask

    task automatic drive();
        @(posedge clk);
        cyc++;
        #1;
        if (bus.rd_busy) begin
            cnt--;
            if (cnt == 0) begin
                bus.rd_busy = 1'b0;
                bus.rd_data = mem_word(r_addr);
            end else begin
                bus.rd_data = $urandom;
            end
        end else if (snap_start) begin
            bus.rd_busy = 1'b1;
            cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 8));
            r_addr = snap_addr;
            bus.rd_data = $urandom;
            // Reader busy spans cnt cycles; response lands the cycle after it drops.
            if (outst && !hit && due == NEVER) due = cyc + 1 + cnt;
        end
        for (int i = 0; i < N; i++) begin
            if (snap_grant == i) begin
                if (mode != 1) bus.req_valid[i] = 1'b0;
            end else if (mode == 2) begin
                if (bus.req_valid[i]) begin
                    if ($urandom_range(0, 19) == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_addr[i*AW +: AW] = pick_addr();
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        drive();
    endtask

    task automatic reset_pulse();
        #1;
        rst_n = 1'b0;
        mode = 0;
        bus.req_valid = '0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic single_read(input logic [AW-1:0] a, input int lat,
                               output int g, output int r, output logic [DW-1:0] d);
        mode = 0; lat_fixed = lat;
        t_g = -1; t_r = -1; t_d = '0;
        bus.req_addr[0 +: AW] = a;
        bus.req_valid[0] = 1'b1;
        for (int k = 0; k < 60 && t_r < 0; k++) step();
        step();
        g = t_g; r = t_r; d = t_d;
    endtask

    initial begin
        int g, r, r2;
        logic [DW-1:0] d, d2;
        bit found;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.rd_busy   = 1'b0;
        bus.rd_data   = '0;
        t_g = -1; t_r = -1;
        model_reset();
        for (int k = 0; k < 3; k++) step();
        rst_n = 1'b1;

        // Single request: fixed 4-cycle reader gives accept -> rsp_valid of 4 + 3.
        single_read(24'h010000, 4, g, r, d);
        check("t1_grant_seen", g >= 0, 1);
        check("t1_latency", r - g, 7);
        check("t1_data", d, 32'hDEADBEEF);

        // Same address twice: a hit with the cache returns one cycle after accept.
        single_read(24'h000100, 3, g, r, d);
        check("t5_first_latency", r - g, 6);
        single_read(24'h000100, 3, g, r2, d2);
        check("t5_second_latency", r2 - g, CACHE ? 1 : 6);
        check("t5_same_data", d2, d);
        single_read(24'h000200, 2, g, r, d);
        check("t5_miss_latency", r - g, 5);

        // All four held from reset: grants follow 0,1,2,3,0.
        reset_pulse();
        for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = AW'(32'h0002_0000 + i * 64);
        glog.delete();
        mode = 1; lat_fixed = 2;
        bus.req_valid = '1;
        for (int k = 0; k < 200 && glog.size() < 5; k++) step();
        check("t2_grant_count", glog.size() >= 5, 1);
        for (int k = 0; k < 5; k++) check("t2_grant_order", (k < glog.size()) ? glog[k] : -1, k % N);
        mode = 0;
        bus.req_valid = '0;
        for (int k = 0; k < 20; k++) step();

        // Random traffic with drops, random reader latency and address reuse.
        mode = 2; lat_fixed = 0;
        for (int k = 0; k < 1500; k++) step();

        // Reset while a long read is in WAIT; release with the reader still busy.
        lat_fixed = 8;
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            step();
            found = outst && !hit && bus.rd_busy && cnt >= 4 && cyc >= g_cyc + 3;
        end
        check("rst_window_found", found, 1);
        reset_pulse();
        check("busy_after_release", bus.rd_busy, 1);
        mode = 2; lat_fixed = 0;
        for (int k = 0; k < 1500; k++) step();

        mode = 0;
        bus.req_valid = '0;
        for (int k = 0; k < 30; k++) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
